// File: rtl/i2c_config_sequencer_if.sv
// Link between the config sequencer and the I2C byte-write master.
// Handshake: the sequencer raises i2c_dev_addr[8] with reg/data stable and holds it
// until the master returns a single-clock i2c_we; i2c_status[1] flags a NACK seen
// anywhere during that transaction.
interface i2c_config_sequencer_if;
    logic [8:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_data;
    logic       i2c_we;
    logic [1:0] i2c_status;

    modport master (
        output i2c_dev_addr,
        output i2c_reg_addr,
        output i2c_data,
        input  i2c_we,
        input  i2c_status
    );

    modport slave (
        input  i2c_dev_addr,
        input  i2c_reg_addr,
        input  i2c_data,
        output i2c_we,
        output i2c_status
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Boot-time codec register loader with NACK retry and timeout, then a grant path
// for single host register writes (volume etc.) once initialisation succeeded.
module i2c_config_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         NUM_ENTRIES    = 10,
    parameter int         IDX_W          = 4,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYCLES     = 100,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic [IDX_W-1:0]            rom_index,
    input  logic [15:0]                 rom_entry,
    input  logic                        host_req,
    input  logic [7:0]                  host_reg,
    input  logic [7:0]                  host_data,
    output logic                        host_ack,
    i2c_config_sequencer_if.master      i2c,
    output logic                        busy,
    output logic                        init_done,
    output logic                        error,
    output logic [IDX_W-1:0]            err_index,
    output logic [2:0]                  state_dbg
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_GAP   = 3'd5,
        S_FAIL  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [IDX_W-1:0]   idx;
    logic [RETRY_W-1:0] retry;
    logic               retry_pend;
    logic               is_host;
    logic               nack_seen;
    logic [15:0]        tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               req;
    logic [7:0]         reg_addr;
    logic [7:0]         wr_data;

    logic               accept_start;
    logic               accept_host;
    logic               tmo_hit;
    logic               gap_end;
    logic               last_entry;
    logic               retry_left;
    logic               unused_busy_bit;

    assign tmo_hit    = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign gap_end    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign last_entry = (idx == IDX_W'(NUM_ENTRIES - 1));
    assign retry_left = (retry < RETRY_W'(MAX_RETRY));

    assign unused_busy_bit = i2c.i2c_status[0];

    assign rom_index        = idx;
    assign i2c.i2c_dev_addr = {req, DEV_ADDR};
    assign i2c.i2c_reg_addr = reg_addr;
    assign i2c.i2c_data     = wr_data;
    assign busy             = !((state == S_IDLE) || (state == S_DONE));
    assign state_dbg        = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The !host_ack term stops the still-high host_req from being re-granted
    // in the cycle where the host is only just seeing its acknowledge.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        accept_host  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next   = S_FETCH;
                    accept_start = 1'b1;
                end else if (host_req && init_done && !host_ack) begin
                    state_next  = S_ISSUE;
                    accept_host = 1'b1;
                end
            end
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (i2c.i2c_we) begin
                    state_next = S_CHECK;
                end else if (tmo_hit) begin
                    state_next = S_FAIL;
                end
            end
            S_CHECK: begin
                if (!nack_seen || retry_left) begin
                    state_next = S_GAP;
                end else begin
                    state_next = S_FAIL;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    if (retry_pend) begin
                        state_next = S_ISSUE;
                    end else if (is_host) begin
                        state_next = init_done ? S_DONE : S_IDLE;
                    end else if (last_entry) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FAIL:  state_next = is_host ? S_DONE : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            retry      <= '0;
            retry_pend <= 1'b0;
            is_host    <= 1'b0;
            nack_seen  <= 1'b0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            req        <= 1'b0;
            reg_addr   <= '0;
            wr_data    <= '0;
            host_ack   <= 1'b0;
            init_done  <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept_start) begin
                        idx        <= '0;
                        retry      <= '0;
                        retry_pend <= 1'b0;
                        is_host    <= 1'b0;
                        init_done  <= 1'b0;
                        error      <= 1'b0;
                    end else if (accept_host) begin
                        reg_addr   <= host_reg;
                        wr_data    <= host_data;
                        retry      <= '0;
                        retry_pend <= 1'b0;
                        is_host    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    reg_addr <= rom_entry[15:8];
                    wr_data  <= rom_entry[7:0];
                end
                S_ISSUE: begin
                    req       <= 1'b1;
                    nack_seen <= 1'b0;
                    tmo_cnt   <= '0;
                end
                S_WAIT: begin
                    // The NACK bit is also sampled in the completion cycle itself.
                    nack_seen <= nack_seen | i2c.i2c_status[1];
                    if (i2c.i2c_we) begin
                        req <= 1'b0;
                    end else if (tmo_hit) begin
                        req   <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    gap_cnt <= '0;
                    if (nack_seen && retry_left) begin
                        retry      <= retry + RETRY_W'(1);
                        retry_pend <= 1'b1;
                    end else begin
                        retry_pend <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!gap_end) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end else if (retry_pend) begin
                        retry_pend <= 1'b0;
                    end else if (is_host) begin
                        host_ack <= 1'b1;
                    end else if (!last_entry) begin
                        idx   <= idx + IDX_W'(1);
                        retry <= '0;
                    end else begin
                        init_done <= 1'b1;
                    end
                end
                S_FAIL: begin
                    error <= 1'b1;
                    if (is_host) begin
                        err_index <= '1;
                        host_ack  <= 1'b1;
                    end else begin
                        err_index <= idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for the codec config sequencer: init walk, NACK retry/abort,
// host write grant, transaction timeout and mid-transaction reset.
module tb_i2c_config_sequencer;

  localparam int NUM   = 3;
  localparam int IDXW  = 4;
  localparam int RETRY = 3;
  localparam int GAP   = 8;
  localparam int TMO   = 200;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [IDXW-1:0] rom_index;
  logic [15:0]     rom_entry;
  logic            host_req = 1'b0;
  logic [7:0]      host_reg = 8'h00;
  logic [7:0]      host_data = 8'h00;
  logic            host_ack;
  logic            busy;
  logic            init_done;
  logic            error;
  logic [IDXW-1:0] err_index;
  logic [2:0]      state_dbg;

  i2c_config_sequencer_if bus ();

  i2c_config_sequencer #(
    .DEV_ADDR       (8'h34),
    .NUM_ENTRIES    (NUM),
    .IDX_W          (IDXW),
    .MAX_RETRY      (RETRY),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rom_index (rom_index),
    .rom_entry (rom_entry),
    .host_req  (host_req),
    .host_reg  (host_reg),
    .host_data (host_data),
    .host_ack  (host_ack),
    .i2c       (bus),
    .busy      (busy),
    .init_done (init_done),
    .error     (error),
    .err_index (err_index),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- codec register table ----------------
  logic [15:0] rom_tbl [0:15];
  assign rom_entry = rom_tbl[rom_index];

  // ---------------- I2C master model ----------------
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          req_cyc[$];
  logic [7:0]  nack_reg = 8'hFF;
  int          nack_left = 0;
  logic        we_en = 1'b1;
  logic        active = 1'b0;
  logic        cur_nack = 1'b0;
  int          mcnt = 0;
  int          req_hi_cnt = 0;
  logic        host_seen_init_done = 1'b0;
  int          ack_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      active = 1'b0;
      mcnt = 0;
      bus.i2c_we = 1'b0;
      bus.i2c_status = 2'b00;
    end else if (bus.i2c_we) begin
      bus.i2c_we = 1'b0;
      bus.i2c_status = 2'b00;
      active = 1'b0;
    end else if (active) begin
      if (!bus.i2c_dev_addr[8]) begin
        active = 1'b0;
        bus.i2c_status = 2'b00;
      end else begin
        req_hi_cnt++;
        mcnt++;
        if (mcnt == 2 && cur_nack) bus.i2c_status[1] = 1'b1;
        if (mcnt == 4 && we_en) bus.i2c_we = 1'b1;
      end
    end else if (bus.i2c_dev_addr[8]) begin
      active = 1'b1;
      mcnt = 0;
      req_hi_cnt = 1;
      bus.i2c_status = 2'b01;
      obs_q.push_back({bus.i2c_reg_addr, bus.i2c_data});
      req_cyc.push_back(cyc);
      cur_nack = (bus.i2c_reg_addr == nack_reg) && (nack_left != 0);
      if (cur_nack && nack_left != 255) nack_left--;
      if (bus.i2c_reg_addr == 8'h02) host_seen_init_done = init_done;
    end
  end

  always @(negedge clock) if (host_ack) ack_cnt++;

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_requests(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk($sformatf("%s_req%0d", tag, exp_q.size()), obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    req_cyc.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < max_cyc);
    chk({tag, "_idle_wait"}, busy, 1'b0);
  endtask

  task automatic push_table();
    for (int i = 0; i < NUM; i++) exp_q.push_back(rom_tbl[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack_seen;
    int   n;
    for (int i = 0; i < 16; i++) rom_tbl[i] = 16'hEE00 | 16'(i);
    rom_tbl[0] = 16'h0C00;
    rom_tbl[1] = 16'h0E42;
    rom_tbl[2] = 16'h1012;

    // ---- reset values ----
    repeat (3) @(negedge clock);
    chk("rst_dev_addr", bus.i2c_dev_addr, 9'h034);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_index", err_index, 4'h0);
    chk("rst_host_ack", host_ack, 1'b0);
    chk("rst_rom_index", rom_index, 4'h0);
    chk("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // ---- 1: plain init, all ACK ----
    pulse_start();
    wait_idle("t1", 1000);
    chk("t1_nreq", req_cyc.size(), 3);
    for (int i = 1; i < req_cyc.size(); i++)
      chk($sformatf("t1_spacing%0d", i), (req_cyc[i] - req_cyc[i-1]) >= GAP, 1'b1);
    push_table();
    check_requests("t1");
    chk("t1_init_done", init_done, 1'b1);
    chk("t1_error", error, 1'b0);
    chk("t1_state", state_dbg, ST_DONE);

    // ---- 2: entry 1 NACKs once ----
    nack_reg = 8'h0E;
    nack_left = 1;
    pulse_start();
    wait_idle("t2", 1000);
    exp_q.push_back(rom_tbl[0]);
    exp_q.push_back(rom_tbl[1]);
    exp_q.push_back(rom_tbl[1]);
    exp_q.push_back(rom_tbl[2]);
    check_requests("t2");
    chk("t2_init_done", init_done, 1'b1);
    chk("t2_error", error, 1'b0);

    // ---- 3: entry 2 NACKs always ----
    nack_reg = 8'h10;
    nack_left = 255;
    pulse_start();
    wait_idle("t3", 2000);
    exp_q.push_back(rom_tbl[0]);
    exp_q.push_back(rom_tbl[1]);
    for (int i = 0; i < RETRY + 1; i++) exp_q.push_back(rom_tbl[2]);
    check_requests("t3");
    chk("t3_error", error, 1'b1);
    chk("t3_err_index", err_index, 4'h2);
    chk("t3_init_done", init_done, 1'b0);
    chk("t3_state", state_dbg, ST_IDLE);
    nack_left = 0;

    // ---- 4: host write raised during init ----
    ack_cnt = 0;
    host_seen_init_done = 1'b0;
    pulse_start();
    repeat (5) @(negedge clock);
    host_reg = 8'h02;
    host_data = 8'h79;
    host_req = 1'b1;
    ack_seen = 1'b0;
    n = 0;
    while (!ack_seen && n < 2000) begin
      @(negedge clock);
      n++;
      if (host_ack) begin
        ack_seen = 1'b1;
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    chk("t4_ack_seen", ack_seen, 1'b1);
    repeat (20) @(negedge clock);
    chk("t4_ack_pulses", ack_cnt, 1);
    chk("t4_host_after_init", host_seen_init_done, 1'b1);
    push_table();
    exp_q.push_back(16'h0279);
    check_requests("t4");
    chk("t4_init_done", init_done, 1'b1);
    chk("t4_error", error, 1'b0);
    chk("t4_state", state_dbg, ST_DONE);

    // ---- 5: completion never arrives ----
    we_en = 1'b0;
    pulse_start();
    wait_idle("t5", 600);
    chk("t5_req_high_cycles", req_hi_cnt, TMO);
    chk("t5_dev_addr", bus.i2c_dev_addr, 9'h034);
    chk("t5_error", error, 1'b1);
    chk("t5_err_index", err_index, 4'h0);
    chk("t5_init_done", init_done, 1'b0);
    exp_q.push_back(rom_tbl[0]);
    check_requests("t5");
    we_en = 1'b1;

    // ---- 6: reset while waiting on the master ----
    pulse_start();
    n = 0;
    while (!bus.i2c_dev_addr[8] && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("t6_req_raised", bus.i2c_dev_addr[8], 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_dev_addr", bus.i2c_dev_addr, 9'h034);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rom_index", rom_index, 4'h0);
    chk("t6_state", state_dbg, ST_IDLE);
    chk("t6_error", error, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    obs_q.delete();
    req_cyc.delete();
    @(negedge clock);
    pulse_start();
    wait_idle("t6", 1000);
    push_table();
    check_requests("t6");
    chk("t6_init_done", init_done, 1'b1);
    chk("t6_error_after", error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
